odu_test_gen: RTL
=================

# odu_test_gen

Test-pattern source that emits ODU-like channel words (384-bit data plus valid, frame-start, row-start and MFAS) for the channel test-data checker directly downstream. It builds frames of rows with a fixed overhead field and a continuous modulo-256 incrementing payload byte stream. It also provides idle-gap throttling and single-shot error injection, so the checker's pass and error paths can both be exercised in simulation and on hardware.

## Interface
- WORDS_PER_ROW, 80: 384-bit words per row (≥2)
- ROWS_PER_FRAME, 4: rows per frame (≥1)
- GAP_CYCLES, 0: forced idle cycles after each valid word (0 = back-to-back)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- i_enable  in  1  level; permits word generation
- i_inject_err  in  1  pulse; arms a one-shot payload corruption
- o_data_chid  out  384  word data; byte k at bits [383-8k:376-8k], k=0..47
- o_valid_chid  out  1  word strobe, one cycle per word
- o_fs_chid  out  1  frame start; first word of frame
- o_rs_chid  out  1  row start; first word of every row
- o_mfas_chid  out  8  multiframe counter of current frame
- o_err_injected  out  1  high with the word that carries the injected error

## Operation
- Position state: word_cnt (0..WORDS_PER_ROW-1), row_cnt (0..ROWS_PER_FRAME-1), mfas (8 b), pay_next (8 b, next payload byte value), gap_cnt, err_armed.
- A word is emitted when i_enable=1, gap_cnt=0, and the bench is out of reset. All outputs are registered.
- The rs word is word_cnt=0. Bytes 0..15 are overhead; bytes 16..47 are payload (32 bytes).
  - Overhead on row 0: bytes 0..5 = F6 F6 F6 28 28 28; byte 6 = mfas; bytes 7..15 = 00.
  - Overhead on other rows: bytes 0..15 = 00.
- A non-rs word carries payload in all 48 bytes.
- Payload bytes take the values pay_next, pay_next+1, ... in ascending byte index, all mod 256. After each word, pay_next advances by 32 or 48 (mod 256). The stream is continuous across words, rows, frames and enable pauses.
- o_fs_chid = 1 only when word_cnt=0 and row_cnt=0. o_rs_chid = 1 whenever word_cnt=0.
- o_mfas_chid is constant within a frame. It increments at each fs word (except the first after reset, which uses 0) and wraps 255→0.
- Counter wrap:
  - word_cnt wraps to 0 and increments row_cnt.
  - row_cnt wraps to 0 and starts the next frame.
- Throttle: after each emitted word, gap_cnt loads GAP_CYCLES and decrements by 1 per cycle regardless of i_enable.
- Enable low: no word is emitted and position is held. Generation resumes from the exact next position; no realignment to frame start.
- Injection:
  - A pulse sampled at edge E sets err_armed. Repeated pulses while armed are ignored.
  - The first word registered at an edge after E has its first payload byte XORed with FF and asserts o_err_injected. err_armed clears with that word.
  - pay_next is unaffected, so only one byte is wrong.
- When o_valid_chid=0, o_fs_chid, o_rs_chid and o_err_injected are 0. o_data_chid and o_mfas_chid hold their last values.

## Timing
- Reset values: o_data_chid=0, o_valid_chid=0, o_fs_chid=0, o_rs_chid=0, o_mfas_chid=0, o_err_injected=0. Internal state also resets: word_cnt=0, row_cnt=0, mfas=0, pay_next=0, gap_cnt=0, err_armed=0.
- Reset asserted mid-frame clears all state immediately (asynchronous). The next frame starts from word 0, row 0, MFAS 0, payload 00.
- Latency: i_enable sampled high at edge N gives o_valid_chid high after edge N (first word visible in cycle N+1).
- With GAP_CYCLES=G, the valid duty is one word per G+1 cycles.
- Injection pulse and word emission at the same edge: that word is clean; the next word is corrupted.

## Structure
- Shared package odu_test_pkg holds:
  - FAS byte constants F6/28
  - OH_BYTES=16, WORD_BYTES=48, MFAS_OH_BYTE=6
  - the byte-to-bit-slice mapping function
- Sub-module odu_test_word_fill (combinational): takes pay_next, is_rs, row0 and mfas; produces the 384-bit word. It is instantiated once. Counters, throttle and injection stay in the top level.

## Test plan
- WORDS_PER_ROW=4, ROWS_PER_FRAME=4, G=0; reset, then enable held → word0 has fs=rs=1, mfas=00, bytes 0..6 = F6 F6 F6 28 28 28 00, bytes 16..47 = 00..1F; word1 bytes = 20..4F; word3 bytes = 80..AF; word4 has rs=1, fs=0, OH bytes 00, payload B0..CF.
- Same configuration, run 257 frames → MFAS sequence 00, 01, …, FF, 00; payload continuity checked on every word.
- G=2 → valid asserted every third cycle; i_enable dropped for 5 cycles mid-row → no valid, and the next word continues the payload at exactly +32 or +48.
- i_inject_err pulse between words → the next word's first payload byte = expected ^ FF and o_err_injected=1; the following word is clean. A second pulse while armed produces no extra error.
- Reset asserted for 1 cycle mid-row 2 → outputs 0 immediately; the next word is fs=1, mfas=00, payload from 00.
- The generator drives the downstream checker → the checker's error flag stays low in normal operation and asserts after an injection.

Source files
------------

// File: rtl/odu_test_pkg.sv
// odu_test_pkg
// Shared constants and helpers for the ODU-like test-pattern generator.
// Defines the frame alignment bytes, the word layout in bytes and the
// mapping from a byte index to its bit slice inside a 384-bit word.
package odu_test_pkg;

  localparam logic [7:0] FAS_F6       = 8'hF6;
  localparam logic [7:0] FAS_28       = 8'h28;

  localparam int         OH_BYTES     = 16;
  localparam int         WORD_BYTES   = 48;
  localparam int         MFAS_OH_BYTE = 6;
  localparam int         WORD_BITS    = WORD_BYTES * 8;

  // Byte 0 is the most significant byte: byte k sits at [383-8k:376-8k].
  function automatic int byte_lsb(input int k);
    return (WORD_BYTES - 1 - k) * 8;
  endfunction

endpackage

// File: rtl/odu_test_word_fill.sv
// odu_test_word_fill
// Combinational builder for one 384-bit channel word.
// Ports:
//   pay_next  in   8  value of the first payload byte of this word
//   is_rs     in   1  word is the first of a row (carries 16 overhead bytes)
//   row0      in   1  row is the first of the frame (FAS + MFAS overhead)
//   mfas      in   8  multiframe counter inserted in overhead byte 6 of row 0
//   word      out 384 assembled word, byte 0 in the MSBs
module odu_test_word_fill
  import odu_test_pkg::*;
(
  input  logic [7:0]           pay_next,
  input  logic                 is_rs,
  input  logic                 row0,
  input  logic [7:0]           mfas,
  output logic [WORD_BITS-1:0] word
);

  // Overhead byte k of a row-start word.
  function automatic logic [7:0] oh_byte(input int k, input logic is_row0,
                                         input logic [7:0] mfas_val);
    logic [7:0] b;
    if (!is_row0) begin
      b = 8'h00;
    end else if (k < 3) begin
      b = FAS_F6;
    end else if (k < 6) begin
      b = FAS_28;
    end else if (k == MFAS_OH_BYTE) begin
      b = mfas_val;
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // Payload counts up from pay_next starting at the first non-overhead byte.
  always_comb begin
    word = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (is_rs && (k < OH_BYTES)) begin
        word[byte_lsb(k) +: 8] = oh_byte(k, row0, mfas);
      end else if (is_rs) begin
        word[byte_lsb(k) +: 8] = pay_next + 8'(k - OH_BYTES);
      end else begin
        word[byte_lsb(k) +: 8] = pay_next + 8'(k);
      end
    end
  end

endmodule

// File: rtl/odu_test_gen.sv
// odu_test_gen
// Test-pattern source producing ODU-like channel words: frames of rows with
// a fixed overhead field and a continuous mod-256 incrementing payload
// stream, plus idle-gap throttling and one-shot payload error injection.
// Ports:
//   clk            in   1   clock
//   rst            in   1   asynchronous active-high reset
//   i_enable       in   1   level, permits word generation
//   i_inject_err   in   1   pulse, arms a one-shot payload corruption
//   o_data_chid    out 384  word data (byte 0 in MSBs)
//   o_valid_chid   out  1   one-cycle strobe per word
//   o_fs_chid      out  1   first word of frame
//   o_rs_chid      out  1   first word of every row
//   o_mfas_chid    out  8   multiframe counter of the current frame
//   o_err_injected out  1   marks the word carrying the injected error
module odu_test_gen
  import odu_test_pkg::*;
#(
  parameter int WORDS_PER_ROW  = 80,
  parameter int ROWS_PER_FRAME = 4,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_inject_err,
  output logic [WORD_BITS-1:0] o_data_chid,
  output logic                 o_valid_chid,
  output logic                 o_fs_chid,
  output logic                 o_rs_chid,
  output logic [7:0]           o_mfas_chid,
  output logic                 o_err_injected
);

  localparam int WW = $clog2(WORDS_PER_ROW);
  localparam int RW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_ROW - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS_PER_FRAME - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES);

  logic [WW-1:0]        word_cnt_q, word_cnt_d;
  logic [RW-1:0]        row_cnt_q, row_cnt_d;
  logic [7:0]           mfas_q, mfas_d;
  logic [7:0]           pay_next_q, pay_next_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                 err_armed_q, err_armed_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fs_q, fs_d;
  logic                 rs_q, rs_d;
  logic [7:0]           mfas_out_q, mfas_out_d;
  logic                 err_inj_q, err_inj_d;

  logic                 emit;
  logic                 is_rs;
  logic                 row0;
  logic [WORD_BITS-1:0] fill_word;
  logic [WORD_BITS-1:0] inj_mask;

  odu_test_word_fill u_fill (
    .pay_next (pay_next_q),
    .is_rs    (is_rs),
    .row0     (row0),
    .mfas     (mfas_q),
    .word     (fill_word)
  );

  // Next-state logic: emission decision, position counters, throttle, injection.
  always_comb begin
    emit        = i_enable && (gap_cnt_q == '0);
    is_rs       = (word_cnt_q == '0);
    row0        = (row_cnt_q == '0);

    word_cnt_d  = word_cnt_q;
    row_cnt_d   = row_cnt_q;
    mfas_d      = mfas_q;
    pay_next_d  = pay_next_q;
    data_d      = data_q;
    mfas_out_d  = mfas_out_q;
    valid_d     = 1'b0;
    fs_d        = 1'b0;
    rs_d        = 1'b0;
    err_inj_d   = 1'b0;

    // The corrupted byte is the first payload byte, which moves past the
    // overhead field on row-start words.
    inj_mask = '0;
    if (!err_armed_q) begin
      inj_mask = '0;
    end else if (is_rs) begin
      inj_mask[byte_lsb(OH_BYTES) +: 8] = 8'hFF;
    end else begin
      inj_mask[byte_lsb(0) +: 8] = 8'hFF;
    end

    // The gap counter runs down even while generation is disabled.
    if (emit) begin
      gap_cnt_d = GAP_LOAD;
    end else if (gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - GW'(1);
    end else begin
      gap_cnt_d = gap_cnt_q;
    end

    // A word emitted on the arming edge stays clean: only an already armed
    // request is consumed, and re-pulses while armed have no effect.
    if (emit && err_armed_q) begin
      err_armed_d = 1'b0;
    end else if (i_inject_err) begin
      err_armed_d = 1'b1;
    end else begin
      err_armed_d = err_armed_q;
    end

    if (emit) begin
      valid_d    = 1'b1;
      fs_d       = is_rs && row0;
      rs_d       = is_rs;
      mfas_out_d = mfas_q;
      err_inj_d  = err_armed_q;
      data_d     = fill_word ^ inj_mask;
      pay_next_d = pay_next_q + (is_rs ? 8'd32 : 8'd48);
      // mfas_q advances at frame end so the next fs word carries the new value.
      if (word_cnt_q == WORD_LAST) begin
        word_cnt_d = '0;
        if (row_cnt_q == ROW_LAST) begin
          row_cnt_d = '0;
          mfas_d    = mfas_q + 8'd1;
        end else begin
          row_cnt_d = row_cnt_q + RW'(1);
        end
      end else begin
        word_cnt_d = word_cnt_q + WW'(1);
      end
    end else begin
      data_d = data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q  <= '0;
      row_cnt_q   <= '0;
      mfas_q      <= 8'h00;
      pay_next_q  <= 8'h00;
      gap_cnt_q   <= '0;
      err_armed_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
      rs_q        <= 1'b0;
      mfas_out_q  <= 8'h00;
      err_inj_q   <= 1'b0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      row_cnt_q   <= row_cnt_d;
      mfas_q      <= mfas_d;
      pay_next_q  <= pay_next_d;
      gap_cnt_q   <= gap_cnt_d;
      err_armed_q <= err_armed_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      fs_q        <= fs_d;
      rs_q        <= rs_d;
      mfas_out_q  <= mfas_out_d;
      err_inj_q   <= err_inj_d;
    end
  end

  assign o_data_chid    = data_q;
  assign o_valid_chid   = valid_q;
  assign o_fs_chid      = fs_q;
  assign o_rs_chid      = rs_q;
  assign o_mfas_chid    = mfas_out_q;
  assign o_err_injected = err_inj_q;

endmodule
